// File: rtl/insight_tl_d_capture.sv
// Passive TileLink D-channel observer: groups beats into messages, checks burst header
// consistency and queues one summary record per captured message for debug readout.
module insight_tl_d_capture #(
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 3,
    parameter int SINK_W   = 1,
    parameter int SIZE_W   = 4,
    parameter int BEATS_W  = 8,
    parameter int DEPTH    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [SIZE_W-1:0]   d_size,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SINK_W-1:0]   d_sink,
    input  logic                d_denied,
    input  logic                d_corrupt,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [2:0]          rec_opcode,
    output logic [1:0]          rec_param,
    output logic [SIZE_W-1:0]   rec_size,
    output logic [SOURCE_W-1:0] rec_source,
    output logic [SINK_W-1:0]   rec_sink,
    output logic                rec_denied,
    output logic                rec_corrupt,
    output logic [BEATS_W-1:0]  rec_beats,
    output logic                err_protocol,
    output logic                overflow,
    output logic [31:0]         msg_count
);
    localparam int LGB = $clog2(DATA_W / 8);
    localparam int AW  = $clog2(DEPTH);
    localparam logic [SIZE_W-1:0]  LGB_S = SIZE_W'(LGB);
    localparam logic [BEATS_W-1:0] ONE   = BEATS_W'(1);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [SINK_W-1:0]   sink;
        logic                denied;
        logic                corrupt;
        logic [BEATS_W-1:0]  beats;
    } rec_t;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t             state, state_nxt;
    rec_t               hdr, beat_rec, push_rec, head_q, head_nxt;
    rec_t               mem [DEPTH];
    logic [BEATS_W-1:0] beats_exp, remaining, skip_cnt;
    logic [AW:0]        wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic               fire, has_data, skipping, hdr_diff;
    logic               push, pop, full, push_ok, rec_valid_q;

    assign fire     = d_valid & d_ready;
    assign has_data = (d_opcode == 3'd1) || (d_opcode == 3'd5);
    assign skipping = (skip_cnt != '0);
    assign hdr_diff = {d_opcode, d_param, d_size, d_source, d_sink} !=
                      {hdr.opcode, hdr.param, hdr.size, hdr.source, hdr.sink};

    always_comb begin
        beats_exp = ONE;
        if (has_data && d_size > LGB_S)
            beats_exp = ONE << (d_size - LGB_S);
    end

    always_comb begin
        beat_rec         = '0;
        beat_rec.opcode  = d_opcode;
        beat_rec.param   = d_param;
        beat_rec.size    = d_size;
        beat_rec.source  = d_source;
        beat_rec.sink    = d_sink;
        beat_rec.denied  = d_denied;
        beat_rec.corrupt = d_corrupt;
        beat_rec.beats   = beats_exp;
    end

    // Next state and record push; clear overrides any beat in the same cycle.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_rec  = beat_rec;
        case (state)
            IDLE: begin
                if (fire && !skipping && enable) begin
                    if (beats_exp == ONE) push = 1'b1;
                    else                  state_nxt = BURST;
                end
            end
            BURST: begin
                push_rec         = hdr;
                push_rec.denied  = hdr.denied | d_denied;
                push_rec.corrupt = hdr.corrupt | d_corrupt;
                if (fire && remaining == ONE) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            push      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Header latch, burst countdown and the skip counter for disabled messages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr          <= '0;
            remaining    <= '0;
            skip_cnt     <= '0;
            err_protocol <= 1'b0;
        end else if (clear) begin
            hdr          <= '0;
            remaining    <= '0;
            skip_cnt     <= '0;
            err_protocol <= 1'b0;
        end else if (fire) begin
            if (state == BURST) begin
                hdr.denied  <= hdr.denied | d_denied;
                hdr.corrupt <= hdr.corrupt | d_corrupt;
                remaining   <= remaining - ONE;
                if (hdr_diff) err_protocol <= 1'b1;
            end else if (skipping) begin
                skip_cnt <= skip_cnt - ONE;
            end else if (enable) begin
                hdr       <= beat_rec;
                remaining <= beats_exp - ONE;
            end else begin
                skip_cnt <= beats_exp - ONE;
            end
        end
    end

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = rec_valid_q & rec_ready;
    assign push_ok = push & (~full | pop);
    assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
    assign rd_nxt  = rd_ptr + (AW+1)'(pop);

    // Output register preloads the next head, bypassing storage when the new record is the head.
    always_comb begin
        head_nxt = mem[rd_nxt[AW-1:0]];
        if (push_ok && rd_nxt == wr_ptr) head_nxt = push_rec;
        if (wr_nxt == rd_nxt)            head_nxt = '0;
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
            overflow    <= 1'b0;
            msg_count   <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rec_valid_q <= 1'b0;
            head_q      <= '0;
            overflow    <= 1'b0;
            msg_count   <= '0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            rec_valid_q <= (wr_nxt != rd_nxt);
            head_q      <= head_nxt;
            if (push && full && !pop)     overflow  <= 1'b1;
            if (push && msg_count != '1)  msg_count <= msg_count + 32'd1;
        end
    end

    assign rec_valid   = rec_valid_q;
    assign rec_opcode  = head_q.opcode;
    assign rec_param   = head_q.param;
    assign rec_size    = head_q.size;
    assign rec_source  = head_q.source;
    assign rec_sink    = head_q.sink;
    assign rec_denied  = head_q.denied;
    assign rec_corrupt = head_q.corrupt;
    assign rec_beats   = head_q.beats;
endmodule

// File: tb/tb_insight_tl_d_capture.sv
// Randomized message-level bench for insight_tl_d_capture with a queue-based record model.
module tb_insight_tl_d_capture;
    localparam int DEPTH = 8;

    logic       clock = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0;
    logic       d_valid = 1'b0, d_ready = 1'b0, rec_ready = 1'b0;
    logic [2:0] d_opcode = '0;
    logic [1:0] d_param = '0;
    logic [3:0] d_size = '0;
    logic [2:0] d_source = '0;
    logic       d_sink = 1'b0, d_denied = 1'b0, d_corrupt = 1'b0;
    logic       rec_valid, rec_sink, rec_denied, rec_corrupt, err_protocol, overflow;
    logic [2:0] rec_opcode, rec_source;
    logic [1:0] rec_param;
    logic [3:0] rec_size;
    logic [7:0] rec_beats;
    logic [31:0] msg_count;
    logic [22:0] got;

    int n_tests = 0, n_fail = 0;
    logic [22:0] exp_q[$];
    logic [31:0] m_count = '0;
    logic        m_ovf = 1'b0, m_err = 1'b0;

    always #5 clock = ~clock;

    insight_tl_d_capture #(.DATA_W(64), .SOURCE_W(3), .SINK_W(1), .SIZE_W(4),
                           .BEATS_W(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
        .d_corrupt(d_corrupt), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_opcode(rec_opcode), .rec_param(rec_param), .rec_size(rec_size),
        .rec_source(rec_source), .rec_sink(rec_sink), .rec_denied(rec_denied),
        .rec_corrupt(rec_corrupt), .rec_beats(rec_beats), .err_protocol(err_protocol),
        .overflow(overflow), .msg_count(msg_count));

    assign got = {rec_opcode, rec_param, rec_size, rec_source, rec_sink,
                  rec_denied, rec_corrupt, rec_beats};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // 64-bit data path: 8 bytes per beat.
    function automatic int nbeats(input logic [2:0] op, input logic [3:0] sz);
        int bytes = 1 << sz;
        if ((op == 3'd1 || op == 3'd5) && bytes > 8) return bytes / 8;
        return 1;
    endfunction

    task automatic model_push(input logic [22:0] r);
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else m_ovf = 1'b1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count = '0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        d_valid = 1'b0; d_ready = 1'b0; rec_ready = 1'b0; clear = 1'b0;
        #1 reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        model_clear();
    endtask

    // Idle cycles carry junk fields but never fire.
    task automatic fire_beat(input logic [2:0] op, input logic [1:0] prm, input logic [3:0] sz,
                             input logic [2:0] src, input logic snk, input logic den,
                             input logic cor, input logic en, input int gap);
        for (int g = 0; g < gap; g++) begin
            d_valid = 1'($urandom_range(0, 1));
            d_ready = d_valid ? 1'b0 : 1'($urandom_range(0, 1));
            d_opcode = 3'($urandom); d_param = 2'($urandom); d_size = 4'($urandom);
            d_source = 3'($urandom); d_sink = 1'($urandom);
            d_denied = 1'($urandom); d_corrupt = 1'($urandom); enable = 1'($urandom);
            tick();
        end
        d_valid = 1'b1; d_ready = 1'b1;
        d_opcode = op; d_param = prm; d_size = sz; d_source = src; d_sink = snk;
        d_denied = den; d_corrupt = cor; enable = en;
        tick();
        d_valid = 1'b0; d_ready = 1'b0;
    endtask

    task automatic send_msg(input logic [2:0] op, input logic [1:0] prm, input logic [3:0] sz,
                            input logic [2:0] src, input logic snk, input logic en,
                            input logic [7:0] den_m, input logic [7:0] cor_m,
                            input int chg, input int gmin, input int gmax);
        int n = nbeats(op, sz);
        logic den = 1'b0, cor = 1'b0;
        logic [2:0] s2 = src + 3'd1;
        for (int i = 0; i < n; i++) begin
            fire_beat(op, prm, sz, (chg > 0 && i >= chg) ? s2 : src, snk, den_m[i], cor_m[i],
                      (i == 0) ? en : 1'b1, int'($urandom_range(gmin, gmax)));
            den |= den_m[i];
            cor |= cor_m[i];
        end
        if (en) begin
            if (chg > 0 && chg < n) m_err = 1'b1;
            model_push({op, prm, sz, src, snk, den, cor, 8'(n)});
        end
    endtask

    task automatic drain();
        int guard = 0;
        int idx = 0;
        rec_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 100) begin
            if (rec_valid) begin
                n_tests++;
                if (got !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL drain_rec[%0d] got %h exp %h", idx, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
                idx++;
            end
            tick();
            guard++;
        end
        n_tests++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if (rec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty rec_valid got %b exp 0", rec_valid);
        end
        rec_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({rec_valid, got, err_protocol, overflow, msg_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b rec=%h err=%b ovf=%b cnt=%0d exp all 0",
                     rec_valid, got, err_protocol, overflow, msg_count);
        end
    endtask

    task automatic test_single();
        send_msg(3'd0, 2'd0, 4'd3, 3'd2, 1'b0, 1'b1, 8'h01, 8'h00, 0, 0, 0);
        n_tests++;
        if ({rec_valid, rec_beats, rec_source, rec_denied} !== {1'b1, 8'd1, 3'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL single_rec got v=%b beats=%0d src=%0d den=%b exp 1/1/2/1",
                     rec_valid, rec_beats, rec_source, rec_denied);
        end
        n_tests++;
        if (msg_count !== 32'd1) begin
            n_fail++;
            $display("FAIL single_count got %0d exp 1", msg_count);
        end
        drain();
    endtask

    task automatic test_burst();
        send_msg(3'd1, 2'd0, 4'd6, 3'd2, 1'b0, 1'b1, 8'h00, 8'h10, 0, 1, 1);
        n_tests++;
        if ({err_protocol, msg_count} !== {1'b0, m_count}) begin
            n_fail++;
            $display("FAIL burst_flags got err=%b cnt=%0d exp 0/%0d", err_protocol, msg_count, m_count);
        end
        drain();
    endtask

    task automatic test_src_change();
        send_msg(3'd1, 2'd0, 4'd6, 3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 3, 0, 1);
        n_tests++;
        if (err_protocol !== 1'b1) begin
            n_fail++;
            $display("FAIL src_change_err got %b exp 1", err_protocol);
        end
        drain();
        send_msg(3'd0, 2'd1, 4'd2, 3'd5, 1'b1, 1'b1, 8'h00, 8'h00, 0, 0, 0);
        n_tests++;
        if (err_protocol !== m_err) begin
            n_fail++;
            $display("FAIL err_sticky got %b exp %b", err_protocol, m_err);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++)
            send_msg(3'd0, 2'($urandom), 4'd2, 3'(i), 1'($urandom), 1'b1, 8'($urandom), 8'h00, 0, 0, 1);
        n_tests++;
        if ({overflow, msg_count} !== {1'b1, 32'd9}) begin
            n_fail++;
            $display("FAIL overflow_flags got ovf=%b cnt=%0d exp 1/9", overflow, msg_count);
        end
        drain();
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            send_msg(3'd6, 2'd0, 4'd1, 3'(i), 1'b0, 1'b1, 8'h00, 8'($urandom), 0, 0, 0);
        rec_ready = 1'b1;
        n_tests++;
        if (got !== exp_q[0]) begin
            n_fail++;
            $display("FAIL full_head got %h exp %h", got, exp_q[0]);
        end
        fire_beat(3'd2, 2'd3, 4'd0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        rec_ready = 1'b0;
        void'(exp_q.pop_front());
        model_push({3'd2, 2'd3, 4'd0, 3'd7, 1'b1, 1'b1, 1'b1, 8'd1});
        n_tests++;
        if ({overflow, msg_count} !== {1'b0, 32'd9}) begin
            n_fail++;
            $display("FAIL full_pushpop got ovf=%b cnt=%0d exp 0/9", overflow, msg_count);
        end
        drain();
    endtask

    task automatic test_skip();
        do_reset();
        send_msg(3'd5, 2'd1, 4'd5, 3'd1, 1'b0, 1'b0, 8'hFF, 8'hFF, 0, 0, 1);
        send_msg(3'd0, 2'd0, 4'd3, 3'd4, 1'b1, 1'b1, 8'h00, 8'h00, 0, 0, 1);
        n_tests++;
        if ({msg_count, err_protocol} !== {32'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL skip_count got cnt=%0d err=%b exp 1/0", msg_count, err_protocol);
        end
        drain();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int i = 0; i < 3; i++)
            fire_beat(3'd1, 2'd0, 4'd6, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        do_reset();
        send_msg(3'd0, 2'd0, 4'd3, 3'd3, 1'b0, 1'b1, 8'h00, 8'h00, 0, 0, 0);
        n_tests++;
        if ({msg_count, err_protocol, overflow, rec_beats} !== {32'd1, 1'b0, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_midburst got cnt=%0d err=%b ovf=%b beats=%0d exp 1/0/0/1",
                     msg_count, err_protocol, overflow, rec_beats);
        end
        drain();
    endtask

    task automatic test_clear();
        send_msg(3'd0, 2'd0, 4'd0, 3'd1, 1'b0, 1'b1, 8'h00, 8'h00, 0, 0, 0);
        send_msg(3'd1, 2'd0, 4'd4, 3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 1, 0, 0);
        clear = 1'b1;
        fire_beat(3'd0, 2'd0, 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        clear = 1'b0;
        model_clear();
        n_tests++;
        if ({rec_valid, msg_count, overflow, err_protocol} !== '0) begin
            n_fail++;
            $display("FAIL clear_state got v=%b cnt=%0d ovf=%b err=%b exp all 0",
                     rec_valid, msg_count, overflow, err_protocol);
        end
        send_msg(3'd5, 2'd2, 4'd4, 3'd6, 1'b1, 1'b1, 8'h02, 8'h01, 0, 0, 0);
        drain();
    endtask

    task automatic test_random();
        logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int nmsg = int'($urandom_range(1, 11));
            int gmax = (r == 0) ? 0 : 2;
            for (int m = 0; m < nmsg; m++)
                send_msg(ops[$urandom_range(0, 5)], 2'($urandom), 4'($urandom_range(0, 6)),
                         3'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                         8'($urandom), 8'($urandom), 0, 0, gmax);
            n_tests++;
            if ({overflow, msg_count, err_protocol} !== {m_ovf, m_count, m_err}) begin
                n_fail++;
                $display("FAIL random_flags[%0d] got ovf=%b cnt=%0d err=%b exp %b/%0d/%b",
                         r, overflow, msg_count, err_protocol, m_ovf, m_count, m_err);
            end
            drain();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_src_change();
        test_overflow();
        test_full_pushpop();
        test_skip();
        test_reset_midburst();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/insight_tl_d_capture.md
Name: insight_tl_d_capture

Overview:
Parametrised successor to the per-hart TileLink D-channel insight bundle. It passively observes one D channel, groups beats into messages (single- and multi-beat), and checks header consistency across a burst. It pushes one summary record per completed message into a DEPTH-entry FIFO for debug/trace readout over a valid/ready port. It sits beside the hart's D-channel tap and never drives or back-pressures the observed channel.

Parameters:
DATA_W, 64, D-channel data width in bits (power of 2, >=8); beat bytes = DATA_W/8, LGB = log2(DATA_W/8)
SOURCE_W, 3, d_source width
SINK_W, 1, d_sink width
SIZE_W, 4, d_size width (log2 bytes)
BEATS_W, 8, width of beat counter / rec_beats; bursts longer than 2^BEATS_W-1 beats are out of scope
DEPTH, 8, record FIFO entries (power of 2, >=2)

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
enable  in  1  capture enable, sampled on first beat of a message only
clear  in  1  synchronous clear of FIFO, FSM, flags, counters
d_valid  in  1  observed D valid
d_ready  in  1  observed D ready
d_opcode  in  3  observed opcode
d_param  in  2  observed param
d_size  in  SIZE_W  observed size
d_source  in  SOURCE_W  observed source
d_sink  in  SINK_W  observed sink
d_denied  in  1  observed denied
d_corrupt  in  1  observed corrupt
rec_valid  out  1  record available
rec_ready  in  1  consumer accepts record
rec_opcode  out  3  message opcode
rec_param  out  2  message param
rec_size  out  SIZE_W  message size
rec_source  out  SOURCE_W  message source
rec_sink  out  SINK_W  message sink
rec_denied  out  1  OR of denied over all beats
rec_corrupt  out  1  OR of corrupt over all beats
rec_beats  out  BEATS_W  beats observed in message
err_protocol  out  1  sticky: header field changed mid-burst
overflow  out  1  sticky: record dropped because FIFO full
msg_count  out  32  saturating count of completed captured messages, including dropped ones

Behaviour:
- Beat fire = d_valid & d_ready. No other D signal is examined on cycles without a fire.
- Data-carrying opcodes: 1 (AccessAckData) and 5 (GrantData).
- Expected beats = 1 if the opcode has no data or d_size <= LGB; otherwise 1 << (d_size - LGB).
- FSM has two states, IDLE and BURST. Reset and clear both force IDLE.
- IDLE, fire with enable=1:
  - Latch the header (opcode, param, size, source, sink), denied, and corrupt.
  - If expected=1: push the record this cycle and stay in IDLE.
  - Otherwise: remaining = expected-1, go to BURST.
- IDLE, fire with enable=0: ignore the beat and the rest of its message.
  - A separate skip counter absorbs the remaining expected-1 beats in a SKIP sub-mode. Those beats produce no record and no count.
- BURST, each fire:
  - OR denied and corrupt into the accumulators.
  - If opcode, param, size, source, or sink differs from the latched header, set err_protocol. The latched header is kept.
  - Decrement remaining. When the decrement reaches 0, push the record and return to IDLE.
  - enable is ignored in BURST.
- Record push: rec_beats = expected. msg_count increments and saturates at 0xFFFFFFFF.
- FIFO:
  - Registered outputs. rec_* reflect the head entry whenever rec_valid=1. Pop = rec_valid & rec_ready.
  - A pushed record becomes visible on rec_valid the cycle after the last-beat fire (1-cycle latency).
  - Push when full and no pop in the same cycle: the record is dropped, overflow is set, and msg_count still increments.
  - Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle when empty: the record goes into storage, rec_valid is asserted next cycle, and the pop is a no-op since rec_valid=0.
  - Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- clear=1 has priority over every event in that cycle:
  - Empties the FIFO, zeroes err_protocol, overflow, msg_count, and accumulators, and returns the FSM to IDLE.
  - A beat firing in the same cycle is discarded.
- Reset values: rec_valid=0, all rec_* fields=0, err_protocol=0, overflow=0, msg_count=0, FSM=IDLE.
- Reset asserted mid-burst aborts the burst immediately. The first fire after reset is treated as a new message header.

Test Plan:
- DATA_W=64, enable=1, one fire of opcode=0 (AccessAck), size=3, source=2, denied=1 -> next cycle rec_valid=1, rec_beats=1, rec_source=2, rec_denied=1, msg_count=1.
- Opcode=1, size=6, 8 fires with d_valid toggled every other cycle, corrupt=1 on beat 5 only -> exactly one record, rec_beats=8, rec_corrupt=1, err_protocol=0.
- Same 8-beat burst but d_source changes 2->3 on beat 4 -> err_protocol=1 sticky, rec_source=2, rec_beats=8.
- DEPTH=8, rec_ready=0, 9 single-beat messages -> 8 records held, overflow=1, msg_count=9. Then drain with rec_ready=1 -> records pop in order and rec_valid falls after the 8th pop.
- enable=0 during the first beat of a 4-beat GrantData (size=5), then enable=1 mid-burst -> no record. The next single-beat message is captured as a new header.
- Assert reset after beat 3 of an 8-beat burst, release, then a single-beat AccessAck -> only one record, rec_beats=1, all flags 0. Separately, assert clear and push together -> FIFO empty and msg_count=0.
